// File: rtl/axi4_lite_req_arbiter.sv
// axi4_lite_req_arbiter: round-robin share of one AXI4-Lite master command port; define ARB_TIMEOUT_EN to add the WAIT watchdog (and its TIMEOUT_CYCLES parameter)
module axi4_lite_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32
`ifdef ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_done,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic [ADDR_W-1:0]            addr,
  output logic                         write,
  output logic [DATA_W-1:0]            wdata,
  output logic                         transfer,
  input  logic                         ready,
  input  logic [DATA_W-1:0]            rdata
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d, grant_q, grant_d, pick, cand;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d, rsp_done_q, rsp_done_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rsp_err_q, rsp_err_d, busy_q, busy_d, write_q, write_d, transfer_q, transfer_d;
  logic                expire;
  logic [ADDR_W-1:0]   a_sl [NUM_REQ];
  logic [DATA_W-1:0]   d_sl [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_sl
    assign a_sl[i] = req_addr[i*ADDR_W +: ADDR_W];
    assign d_sl[i] = req_wdata[i*DATA_W +: DATA_W];
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign expire = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  // watchdog: cleared on grant, counts every WAIT edge
  always_ff @(posedge ACLK) begin
    if (ARESET) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt_d = (state_q == S_IDLE) ? '0 : cnt_q + 1'b1;
`else
  assign expire = 1'b0;
`endif

  // first valid requester at or after ptr, wrapping; scanned downward so the nearest wins
  always_comb begin
    pick = ptr_q;
    cand = ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (req_valid[cand]) pick = cand;
    end
  end

  // grant in IDLE, complete (ready or watchdog) in WAIT; pulses default low
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    busy_d      = busy_q;
    req_ready_d = '0;
    rsp_done_d  = '0;
    transfer_d  = 1'b0;
    if (state_q == S_IDLE) begin
      if (|req_valid) begin
        state_d           = S_WAIT;
        grant_d           = pick;
        addr_d            = a_sl[pick];
        write_d           = req_write[pick];
        wdata_d           = d_sl[pick];
        req_ready_d[pick] = 1'b1;
        transfer_d        = 1'b1;
        busy_d            = 1'b1;
      end
    end else if (ready || expire) begin
      state_d              = S_IDLE;
      busy_d               = 1'b0;
      rsp_done_d[grant_q]  = 1'b1;
      ptr_d                = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
      rsp_err_d            = expire && !ready;
      rsp_rdata_d          = (expire && !ready) ? '0 : write_q ? rsp_rdata_q : rdata;
    end
  end

  // state and registered outputs
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      req_ready_q <= '0;
      rsp_done_q  <= '0;
      transfer_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      req_ready_q <= req_ready_d;
      rsp_done_q  <= rsp_done_d;
      transfer_q  <= transfer_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_done  = rsp_done_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q;
  assign addr      = addr_q;
  assign write     = write_q;
  assign wdata     = wdata_q;
  assign transfer  = transfer_q;
endmodule

// File: tb/tb_axi4_lite_req_arbiter.sv
// tb_axi4_lite_req_arbiter: directed plus randomized stimulus against a transaction-level round-robin model
module tb_axi4_lite_req_arbiter;
  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int IW = 2;
`ifdef ARB_TIMEOUT_EN
  localparam int TO = 8;
`endif

  typedef struct { logic w; logic [AW-1:0] a; logic [DW-1:0] d; } cmd_t;
  typedef struct { int id; logic [DW-1:0] rd; logic err; } done_t;

  logic ACLK = 1'b0, ARESET = 1'b1;
  logic [N-1:0] req_valid = '0, req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0] req_ready, rsp_done;
  logic [DW-1:0] rsp_rdata, wdata;
  logic rsp_err, busy, write, transfer;
  logic [IW-1:0] grant_id;
  logic [AW-1:0] addr;
  logic ready = 1'b0;
  logic [DW-1:0] rdata = '0;

  int n_vec = 0, n_err = 0;

  always #5 ACLK = ~ACLK;

  axi4_lite_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)
`ifdef ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .rsp_done(rsp_done),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .grant_id(grant_id), .busy(busy),
    .addr(addr), .write(write), .wdata(wdata), .transfer(transfer), .ready(ready), .rdata(rdata)
  );

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [N-1:0] e_req_ready = '0, e_rsp_done = '0;
  logic [DW-1:0] e_rdata = '0, e_wdata = '0;
  logic [AW-1:0] e_addr = '0;
  logic [IW-1:0] e_gid = '0;
  logic e_err = 0, e_busy = 0, e_write = 0, e_transfer = 0;
  bit m_ok = 0, m_pending = 0, m_to = 0;
  int m_ptr = 0, m_age = 0, mg = 0;
  int m_glog[$];
  done_t m_dlog[$];

  always @(posedge ACLK) begin
    e_req_ready = '0;
    e_rsp_done  = '0;
    e_transfer  = 0;
    if (ARESET) begin
      e_rdata = '0; e_wdata = '0; e_addr = '0; e_gid = '0;
      e_err = 0; e_busy = 0; e_write = 0;
      m_pending = 0; m_ptr = 0;
    end else if (!m_pending) begin
      if (req_valid != 0) begin
        mg = -1;
        for (int k = 0; k < N; k++)
          if (mg < 0 && ((req_valid >> ((m_ptr + k) % N)) & 1) != 0) mg = (m_ptr + k) % N;
        e_gid       = IW'(mg);
        e_addr      = AW'(req_addr >> (mg * AW));
        e_wdata     = DW'(req_wdata >> (mg * DW));
        e_write     = ((req_write >> mg) & 1) != 0;
        e_req_ready = N'(1) << mg;
        e_transfer  = 1;
        e_busy      = 1;
        m_pending   = 1;
        m_age       = 0;
        m_glog.push_back(mg);
      end
    end else begin
      m_age++;
      m_to = 0;
`ifdef ARB_TIMEOUT_EN
      m_to = !ready && m_age == TO;
`endif
      if (ready || m_to) begin
        e_rsp_done = N'(1) << e_gid;
        e_busy     = 0;
        m_ptr      = (int'(e_gid) + 1) % N;
        e_err      = m_to;
        e_rdata    = m_to ? '0 : e_write ? e_rdata : rdata;
        m_pending  = 0;
        m_dlog.push_back('{int'(e_gid), e_rdata, e_err});
      end
    end
    m_ok = 1;
  end

  // every cycle, all outputs against the model
  always @(negedge ACLK) if (m_ok) begin
    chk("req_ready", 64'(req_ready), 64'(e_req_ready));
    chk("rsp_done",  64'(rsp_done),  64'(e_rsp_done));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
    chk("rsp_err",   64'(rsp_err),   64'(e_err));
    chk("grant_id",  64'(grant_id),  64'(e_gid));
    chk("busy",      64'(busy),      64'(e_busy));
    chk("addr",      64'(addr),      64'(e_addr));
    chk("write",     64'(write),     64'(e_write));
    chk("wdata",     64'(wdata),     64'(e_wdata));
    chk("transfer",  64'(transfer),  64'(e_transfer));
  end

  function automatic int gl(int i);
    return (i < m_glog.size()) ? m_glog[i] : -1;
  endfunction

  function automatic done_t dl(int i);
    done_t z = '{-1, '1, 1'b1};
    return (i < m_dlog.size()) ? m_dlog[i] : z;
  endfunction

  // ---------------- stimulus: requester FIFOs and master ----------------
  cmd_t fifo [N][16];
  int hd [N], tl [N];
  logic [DW-1:0] mem [16];
  bit mp = 0, stuck = 0, stray = 0, force_ready = 0;
  int md = 0, max_lat = 2;

  task automatic push(int i, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
    fifo[i][tl[i] % 16] = '{w, a, d};
    tl[i]++;
  endtask

  function automatic bit pend_reqs();
    for (int i = 0; i < N; i++) if (tl[i] != hd[i]) return 1;
    return 0;
  endfunction

  task automatic present();
    for (int i = 0; i < N; i++) begin
      if (tl[i] != hd[i]) begin
        req_valid[i] = 1'b1;
        req_write[i] = fifo[i][hd[i] % 16].w;
        req_addr[i*AW +: AW] = fifo[i][hd[i] % 16].a;
        req_wdata[i*DW +: DW] = fifo[i][hd[i] % 16].d;
      end else begin
        req_valid[i] = 1'b0;
        req_write[i] = 1'($urandom);
        req_addr[i*AW +: AW] = AW'($urandom);
        req_wdata[i*DW +: DW] = $urandom;
      end
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
    ready = force_ready;
    force_ready = 0;
    rdata = $urandom;
    if (transfer) begin mp = 1; md = $urandom_range(0, max_lat); end
    if (mp && !stuck) begin
      if (md == 0) begin
        ready = 1'b1;
        mp = 0;
        if (write) mem[addr] = wdata; else rdata = mem[addr];
      end else md--;
    end else if (!mp && stray && $urandom_range(0, 7) == 0) ready = 1'b1;
    for (int i = 0; i < N; i++) if (req_ready[i]) hd[i]++;
    present();
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    mp = 0;
    tick();
    ARESET = 1'b0;
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((pend_reqs() || busy || mp) && n < budget) begin tick(); n++; end
    chk("drain_bound", 64'(n < budget), 64'(1));
  endtask

  task automatic wait_transfer(int budget);
    int n = 0;
    while (!transfer && n < budget) begin tick(); n++; end
    chk("transfer_bound", 64'(n < budget), 64'(1));
  endtask

  initial begin
    int s, sd, n;
    for (int i = 0; i < N; i++) begin hd[i] = 0; tl[i] = 0; end
    for (int i = 0; i < 16; i++) mem[i] = '0;
    // reset 2 cycles, then 5 idle cycles
    tick(); tick();
    ARESET = 1'b0;
    repeat (5) tick();
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_transfer", 64'(transfer), 64'(0));
    chk("idle_rdata", 64'(rsp_rdata), 64'(0));
    chk("idle_grants", 64'(m_glog.size()), 64'(0));

    // single write then read by requester 1
    s = m_glog.size(); sd = m_dlog.size();
    push(1, 1, 4'h4, 32'h2);
    push(1, 0, 4'h4, 32'h0);
    drain(200);
    chk("sw_grant0", 64'(gl(s)), 64'(1));
    chk("sw_grant1", 64'(gl(s + 1)), 64'(1));
    chk("sw_done_id", 64'(dl(sd).id), 64'(1));
    chk("sw_read_data", 64'(dl(sd + 1).rd), 64'(32'h2));
    chk("sw_addr", 64'(addr), 64'(4'h4));
    chk("sw_grant_id", 64'(grant_id), 64'(1));

    // round-robin fairness from ptr=0
    do_reset();
    s = m_glog.size(); sd = m_dlog.size();
    for (int i = 0; i < N; i++) push(i, 1, AW'(4 * i), DW'(i + 1));
    for (int i = 0; i < N; i++) push(i, 0, AW'(4 * i), 32'h0);
    drain(400);
    for (int i = 0; i < 8; i++) chk("rr_order", 64'(gl(s + i)), 64'(i % 4));
    for (int i = 0; i < 4; i++) chk("rr_rdata", 64'(dl(sd + 4 + i).rd), 64'(i + 1));

    // ptr back at 0: 1 and 3 contend -> 1 first
    s = m_glog.size();
    push(3, 0, 4'h0, 0);
    push(1, 0, 4'h8, 0);
    drain(200);
    chk("ptr0_first", 64'(gl(s)), 64'(1));
    chk("ptr0_second", 64'(gl(s + 1)), 64'(3));

    // pointer skip: after grant 2, only 0 and 3 -> 3 then 0
    push(2, 0, 4'h4, 0);
    drain(200);
    s = m_glog.size();
    push(0, 0, 4'hC, 0);
    push(3, 0, 4'h4, 0);
    drain(200);
    chk("skip_first", 64'(gl(s)), 64'(3));
    chk("skip_second", 64'(gl(s + 1)), 64'(0));

    // master never answers
    sd = m_dlog.size();
    stuck = 1;
    push(2, 0, 4'h8, 0);
    wait_transfer(50);
`ifdef ARB_TIMEOUT_EN
    n = 0;
    while (rsp_done == 0 && n < 40) begin tick(); n++; end
    chk("to_latency", 64'(n), 64'(TO));
    chk("to_id", 64'(dl(sd).id), 64'(2));
    chk("to_err", 64'(dl(sd).err), 64'(1));
    chk("to_rdata", 64'(dl(sd).rd), 64'(0));
    stuck = 0;
    repeat (8) tick();
`else
    repeat (20) tick();
    chk("stuck_busy", 64'(busy), 64'(1));
    chk("stuck_no_done", 64'(m_dlog.size()), 64'(sd));
    stuck = 0;
    do_reset();
`endif

    // reset one cycle after transfer, then a stray ready
    sd = m_dlog.size();
    stuck = 1;
    push(2, 0, 4'h4, 0);
    wait_transfer(50);
    tick();
    do_reset();
    stuck = 0;
    force_ready = 1;
    tick(); tick();
    chk("rst_no_done", 64'(m_dlog.size()), 64'(sd));
    chk("rst_busy", 64'(busy), 64'(0));
    s = m_glog.size();
    push(3, 0, 4'h0, 0);
    push(0, 0, 4'h0, 0);
    drain(200);
    chk("rst_ptr_first", 64'(gl(s)), 64'(0));
    chk("rst_ptr_second", 64'(gl(s + 1)), 64'(3));

    // randomized traffic with stray readies and occasional resets
    stray = 1;
    max_lat = 4;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (tl[i] - hd[i] < 3 && $urandom_range(0, 3) == 0)
          push(i, 1'($urandom), AW'($urandom), $urandom);
      if ($urandom_range(0, 399) == 0) do_reset(); else tick();
    end
    stray = 0;
    drain(2000);
    chk("rand_grants_seen", 64'(m_glog.size() > 100), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axi4_lite_req_arbiter.md
Name: axi4_lite_req_arbiter

Overview:
- Round-robin arbiter that shares one AXI4_Lite_Master user-side command port (addr/write/wdata/transfer/ready/rdata) between NUM_REQ requesters, e.g. CPU data port, DMA and debug.
- Accepts a command from one requester, issues a single-cycle transfer pulse to the master, waits for ready, then returns completion and read data to the granted requester.
- Sits between the requesters and AXI4_Lite_Master.
- One outstanding transaction at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 4, command address width (matches master addr).
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 64, WAIT-state watchdog limit. Used only when ARB_TIMEOUT_EN is defined.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  reset. Synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_write  in  NUM_REQ  per-requester 1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing.
- req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester.
- rsp_done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- rsp_rdata  out  DATA_W  shared read-data return.
- rsp_err  out  1  timeout flag, qualified by rsp_done.
- grant_id  out  $clog2(NUM_REQ)  index of the current/last grant.
- busy  out  1  high while a transaction is outstanding.
- addr  out  ADDR_W  to master.
- write  out  1  to master.
- wdata  out  DATA_W  to master.
- transfer  out  1  to master; one-cycle start pulse.
- ready  in  1  from master; completion pulse.
- rdata  in  DATA_W  from master; valid when ready=1.

Behaviour:
- All outputs are registered.
- Reset (ARESET sampled high): state=IDLE, rr pointer ptr=0, and every output cleared to 0 (req_ready, rsp_done, rsp_rdata, rsp_err, grant_id, busy, addr, write, wdata, transfer).
- Reset mid-transaction: the transaction is abandoned, no rsp_done is issued, and a later stray ready is ignored.
- Requester rule: hold req_valid and its payload stable until req_ready is seen high. Deassert or present a new command afterwards.
- FSM has two states, IDLE and WAIT.
- IDLE, on an edge where any req_valid=1:
  - g = first requester with req_valid set, searching upward from ptr and wrapping at NUM_REQ-1 -> 0.
  - Latch req_addr/req_write/req_wdata slice g into addr/write/wdata.
  - grant_id<=g; req_ready[g]<=1; transfer<=1; busy<=1; state<=WAIT.
- IDLE with no req_valid: outputs hold; transfer, req_ready and rsp_done are 0.
- WAIT, first edge: req_ready<=0 and transfer<=0, so both are exactly one cycle wide.
- WAIT, on an edge where ready=1:
  - rsp_done[g]<=1 for one cycle; busy<=0; ptr<=(g+1) mod NUM_REQ; state<=IDLE.
  - Read (write=0): rsp_rdata<=rdata. Write: rsp_rdata holds its previous value.
  - rsp_err<=0.
- ready is honoured on any WAIT edge, including the edge that clears transfer. ready seen in IDLE is ignored.
- addr, write and wdata stay stable from grant until the next grant.
- Throughput: minimum of one IDLE edge between a completion and the next grant.
- A requester may assert a new req_valid in the same cycle as its rsp_done. It then competes normally under rr; it has lowest priority relative to ptr.
- Single requester: gets back-to-back grants regardless of ptr.
- req_valid changing while in WAIT has no effect.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on grant and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with no ready: rsp_done[g]<=1, rsp_err<=1, rsp_rdata<=0, ptr advances, state<=IDLE.
  - A late ready arriving afterwards is ignored unless the FSM is in WAIT for a new grant.
- Not defined:
  - No counter; WAIT lasts until ready.
  - rsp_err is constant 0. The port remains present.

Test Plan:
- Reset then idle: hold ARESET 2 cycles, then no requests for 5 cycles -> all outputs 0, busy=0, no transfer pulse.
- Single write/read: req1 writes addr 4'h4 data 32'h2, then req1 reads 4'h4 -> transfer pulses are 1 cycle, addr=4'h4, rsp_done[1] once per transaction, read gives rsp_rdata=32'h2, grant_id=1.
- Round-robin fairness: all 4 assert req_valid continuously with writes 1..4 to 4'h0/4'h4/4'h8/4'hC, then all read back -> grant order 0,1,2,3,0,1,2,3; read data 1,2,3,4; ptr=0 at end.
- Pointer skip: after grant to 2, only req 0 and 3 valid -> grant 3 then 0.
- Reset mid-WAIT: assert ARESET 1 cycle after transfer, then pulse ready -> no rsp_done, state IDLE, next request from req0 granted first (ptr=0).
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, ready stuck 0: grant req2 -> rsp_done[2] with rsp_err=1 and rsp_rdata=0 after 8 WAIT cycles. Without the macro -> busy stays 1 indefinitely.
